sine_dds: RTL

Direct-digital-synthesis sine source for the SineWave datapath. It produces one sine sample every DIV clocks from a phase accumulator and a quarter-wave ROM. Samples are offset-binary, zero-extended to 32 bits, and drive the DAC stage's 32-bit `I_data` input directly. Output frequency is f_clk / DIV × FCW / 2^PHASE_W.

---
 rtl/sine_pkg.sv | 43 ++++
 rtl/sine_dds_if.sv | 23 ++
 rtl/sine_quarter_rom.sv | 28 ++
 rtl/sine_dds.sv | 128 ++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared constants and elaboration-time helpers for the sine DDS.
// Holds default geometry, the offset-binary midpoint and the dither LFSR constants.
package sine_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int LUT_AW_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int DIV_DEF     = 100;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // pi in unsigned Q4.60
  localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

  function automatic logic [31:0] mid_val(input int data_w);
    return 32'd1 << (data_w - 1);
  endfunction

  // round((2^(data_w-1)-1) * sin(pi/2 * (idx+0.5)/2^lut_aw)) via a Q60 Taylor series
  function automatic logic [31:0] quarter_sine(input int idx, input int lut_aw, input int data_w);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc;
    logic [127:0] amp;
    x    = (128'(PI_Q60) * 128'(2 * idx + 1)) >> (lut_aw + 2);
    x2   = (x * x) >> 60;
    term = x;
    acc  = x;
    for (int k = 1; k < 14; k++) begin
      term = (term * x2) >> 60;
      term = term / 128'((2 * k) * (2 * k + 1));
      if ((k % 2) == 1) acc = acc - term;
      else              acc = acc + term;
    end
    amp = 128'((64'd1 << (data_w - 1)) - 64'd1);
    acc = (amp * acc + (128'd1 << 59)) >> 60;
    return acc[31:0];
  endfunction

endpackage

// File: rtl/sine_dds_if.sv
// Control and sample bus between the sine DDS and its controller / DAC stage.
interface sine_dds_if
  import sine_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
);
  logic               I_enable;
  logic [PHASE_W-1:0] I_fcw;
  logic               I_fcw_load;
  logic               O_fcw_ack;
  logic [31:0]        O_data;
  logic               O_valid;

  modport master (
    output I_enable, I_fcw, I_fcw_load,
    input  O_fcw_ack, O_data, O_valid
  );

  modport slave (
    input  I_enable, I_fcw, I_fcw_load,
    output O_fcw_ack, O_data, O_valid
  );
endinterface

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM with registered read (lookup stage S2).
// Contents are generated at elaboration from the package's quarter_sine function.
module sine_quarter_rom
  import sine_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [DATA_W-2:0] o_q
);
  localparam int DEPTH = 1 << LUT_AW;

  logic [DATA_W-2:0] w_rom [DEPTH];
  logic [DATA_W-2:0] r_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [31:0] ENTRY = quarter_sine(g, LUT_AW, DATA_W);
    assign w_rom[g] = ENTRY[DATA_W-2:0];
  end

  always_ff @(posedge clk) begin
    r_q <= w_rom[i_addr];
  end

  assign o_q = r_q;
endmodule

// File: rtl/sine_dds.sv
// Sine DDS: tick divider, phase accumulator with shadowed FCW, 3-stage quarter-wave lookup.
// Optional lookup-phase dither is enabled by defining SINE_DDS_DITHER_EN.
module sine_dds
  import sine_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIV     = DIV_DEF
) (
  input  logic      clk,
  input  logic      rst,
  sine_dds_if.slave bus
);
  localparam int              CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [31:0]     MID      = mid_val(DATA_W);

  logic [CNT_W-1:0]   r_cnt;
  logic               r_tick;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_fcw_active;
  logic [PHASE_W-1:0] r_fcw_shadow;
  logic               r_pending;

  logic [PHASE_W-1:0] w_look_phase;
  logic [1:0]         w_q;
  logic [LUT_AW-1:0]  w_a;
  logic               w_unused_phase;

  logic               r_s1_v;
  logic [LUT_AW-1:0]  r_s1_addr;
  logic               r_s1_neg;
  logic               r_s2_v;
  logic               r_s2_neg;
  logic [DATA_W-2:0]  w_rom_q;
  logic [31:0]        r_data;
  logic               r_valid;

  // tick is registered so the tick cycle lands DIV clocks after enable rises
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= bus.I_enable && (r_cnt == CNT_LAST);
      if (!bus.I_enable || (r_cnt == CNT_LAST)) r_cnt <= '0;
      else                                      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= '0;
      r_fcw_active <= '0;
      r_fcw_shadow <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (r_tick) begin
        r_phase <= r_phase + r_fcw_active;
        if (r_pending) r_fcw_active <= r_fcw_shadow;
      end
      if (bus.I_fcw_load) begin
        r_fcw_shadow <= bus.I_fcw;
        r_pending    <= 1'b1;
      end else if (r_tick) begin
        r_pending <= 1'b0;
      end
    end
  end

`ifdef SINE_DDS_DITHER_EN
  localparam int                 SUB_W    = PHASE_W - 2 - LUT_AW;
  localparam logic [PHASE_W-1:0] SUB_MASK = (PHASE_W'(1) << SUB_W) - PHASE_W'(1);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst)         r_lfsr <= LFSR_SEED;
    else if (r_tick) r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  // dither touches only the bits below the ROM address; the accumulator stays clean
  assign w_look_phase = r_phase + (PHASE_W'(r_lfsr) & SUB_MASK);
`else
  assign w_look_phase = r_phase;
`endif

  assign w_q            = w_look_phase[PHASE_W-1 -: 2];
  assign w_a            = w_look_phase[PHASE_W-3 -: LUT_AW];
  assign w_unused_phase = ^w_look_phase;

  sine_quarter_rom #(
    .LUT_AW(LUT_AW),
    .DATA_W(DATA_W)
  ) u_rom (
    .clk   (clk),
    .i_addr(r_s1_addr),
    .o_q   (w_rom_q)
  );

  // quadrants 1 and 3 read the table mirrored; 2 and 3 negate around MID
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_addr <= '0;
      r_s1_neg  <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s2_neg  <= 1'b0;
      r_data    <= MID;
      r_valid   <= 1'b0;
    end else begin
      r_s1_v <= r_tick;
      if (r_tick) begin
        r_s1_addr <= w_q[0] ? ~w_a : w_a;
        r_s1_neg  <= w_q[1];
      end
      r_s2_v   <= r_s1_v;
      r_s2_neg <= r_s1_neg;
      r_valid  <= r_s2_v;
      if (r_s2_v) r_data <= r_s2_neg ? (MID - 32'(w_rom_q)) : (MID + 32'(w_rom_q));
    end
  end

  assign bus.O_data    = r_data;
  assign bus.O_valid   = r_valid;
  assign bus.O_fcw_ack = r_tick & r_pending & ~rst;
endmodule
